// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the board serial link (receiver and transmitter).
//   Contents:
//     UART_DATA_BITS  payload bits per frame (8N1 framing)
//     rx_state_t      receiver FSM state encoding
//     majority3       2-of-3 vote used by the optional receive filter
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_t;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input.
//   Parameters:
//     RST_VAL  value both flops take on reset (idle level of the line)
//   Ports:
//     clk    in  1  system clock
//     rst_n  in  1  synchronous active-low reset
//     d      in  1  asynchronous input
//     q      out 1  synchronized output, two cycles behind d
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver. The serial line is synchronized, the start edge is
//   qualified at mid start bit, then each data bit (LSB first) and the stop
//   bit are sampled one bit time apart, i.e. at mid-bit.
//   Parameters:
//     CLKS_PER_BIT  clk cycles per bit time, 4..65535
//   Ports:
//     clk          in  1  system clock
//     rst_n        in  1  synchronous active-low reset
//     rx_i         in  1  asynchronous serial line, idle high
//     data_o       out 8  last good byte, held until the next good frame
//     valid_o      out 1  one-cycle strobe: data_o updated
//     frame_err_o  out 1  one-cycle strobe: stop bit low, data_o kept
//     busy_o       out 1  receiver is not idle
//   Build option:
//     UART_RX_MAJORITY_EN  when defined, every sample is a 2-of-3 vote over
//                          the current and two previous synchronized values.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  output logic                      frame_err_o,
  output logic                      busy_o
);

  localparam logic [15:0] HALF     = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state, state_nxt;
  logic [15:0]               cnt, cnt_nxt;
  logic [2:0]                bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic [UART_DATA_BITS-1:0] data_nxt;
  logic                      valid_nxt;
  logic                      frame_err_nxt;
  logic                      rx_s;
  logic                      s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_i),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous rx_s values; together with rx_s they form the 3-deep vote
  // window, so the sample point (and latency) is unchanged.
  logic [1:0] rx_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_hist <= 2'b11;
    end else begin
      rx_hist <= {rx_hist[0], rx_s};
    end
  end

  assign s = majority3({rx_hist, rx_s});
`else
  assign s = rx_s;
`endif

  assign busy_o = (state != R_IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    data_nxt      = data_o;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      R_IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        // Start detection uses the raw synchronized line; the vote only
        // applies at sample points.
        if (!rx_s) begin
          state_nxt = R_START;
        end
      end

      R_START: begin
        if (cnt == HALF) begin
          cnt_nxt = '0;
          // High at mid start bit means the falling edge was a glitch.
          state_nxt = s ? R_IDLE : R_DATA;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      R_DATA: begin
        if (cnt == LAST) begin
          cnt_nxt            = '0;
          shreg_nxt[bit_idx] = s;
          if (bit_idx == LAST_BIT) begin
            bit_idx_nxt = '0;
            state_nxt   = R_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      R_STOP: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          // Leaving at mid stop bit leaves half a bit to catch the next
          // start edge of a back-to-back frame.
          if (s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = R_IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = R_BREAK;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      R_BREAK: begin
        // A line held low reports one framing error, not a stream of frames.
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = R_IDLE;
        end
      end

      default: begin
        state_nxt   = R_IDLE;
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= R_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shreg       <= shreg_nxt;
      data_o      <= data_nxt;
      valid_o     <= valid_nxt;
      frame_err_o <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Self-checking bench for uart_rx at 16 clocks per bit. Frames are driven
//   bit by bit onto rx_i; each completed frame pushes its expected outcome
//   into a queue, and a negedge monitor pops and compares on every strobe.
//   Honours UART_RX_MAJORITY_EN for the glitched-frame expectation.
module tb_uart_rx;

  localparam int CLKS = 16;
  localparam int HALF = (CLKS - 1) / 2;

`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i  = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t       exp_q[$];
  logic [7:0] model_data = 8'h00;

  int   pulse_cyc     = 0;
  int   pulse_count   = 0;
  int   err_count     = 0;
  int   busy_falls    = 0;
  int   busy_run      = 0;
  int   last_busy_run = 0;
  logic busy_prev     = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Scoreboard monitor plus busy_o run tracking.
  always @(negedge clk) begin
    exp_t e;
    if (valid_o || frame_err_o) begin
      check_output("pulse_exclusive", {31'd0, valid_o & frame_err_o}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: valid=%0b frame_err=%0b data=%0h (cycle %0d)",
                 valid_o, frame_err_o, data_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check_output("pulse_kind_err", {31'd0, frame_err_o}, {31'd0, e.is_err});
        check_output("data_o", {24'd0, data_o}, {24'd0, e.data});
      end
      pulse_cyc = cyc;
      pulse_count++;
      if (frame_err_o) err_count++;
    end
    if (busy_o) begin
      busy_run++;
    end else begin
      if (busy_prev) begin
        busy_falls++;
        last_busy_run = busy_run;
      end
      busy_run = 0;
    end
    busy_prev = busy_o;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_bit(input logic v, input bit glitch);
    for (int i = 0; i < CLKS; i++) begin
      rx_i = (glitch && i == HALF + 1) ? ~v : v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame and records the outcome the receiver should report.
  // A glitch inverts the line for one cycle at the mid point of each data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch,
                            output int start_cyc);
    exp_t       e;
    logic [7:0] got;
    got = (glitch && !MAJ) ? ~b : b;
    if (stop) begin
      model_data = got;
      e.is_err   = 1'b0;
      e.data     = got;
    end else begin
      e.is_err = 1'b1;
      e.data   = model_data;
    end
    exp_q.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
    drive_bit(stop, 1'b0);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    rx_i = 1'b1;
    while ((busy_o || exp_q.size() != 0) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drain_in_time", {31'd0, (busy_o || exp_q.size() != 0)}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int         t0;
    int         falls0;
    int         pulses0;
    int         errs0;
    logic [7:0] b;
    bit         bad;
    logic [7:0] partial;

    // Reset state
    rx_i  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_data_o", {24'd0, data_o}, 32'd0);
    check_output("reset_valid_o", {31'd0, valid_o}, 32'd0);
    check_output("reset_frame_err_o", {31'd0, frame_err_o}, 32'd0);
    check_output("reset_busy_o", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Single frame and its latency (rx_s trails rx_i by two cycles)
    errs0 = err_count;
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    wait_idle(200);
    check_output("latency_a5", pulse_cyc - t0, 2 + 9 * CLKS + HALF + 2);
    check_output("no_err_a5", err_count - errs0, 0);
    idle(4);

    // Back-to-back frames with no idle gap
    falls0 = busy_falls;
    send_frame(8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b0, t0);
    wait_idle(200);
    check_output("busy_falls_b2b", busy_falls - falls0, 2);
    idle(4);

    // Short low pulse is rejected at mid start bit
    pulses0 = pulse_count;
    rx_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rx_i = 1'b1;
    wait_idle(50);
    check_output("glitch_busy_len", last_busy_run, HALF + 1);
    check_output("glitch_no_pulse", pulse_count - pulses0, 0);
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    wait_idle(200);

    // Framing error followed by a held-low line
    errs0 = err_count;
    send_frame(8'h55, 1'b0, 1'b0, t0);
    for (int i = 0; i < 100; i++) begin
      rx_i = 1'b0;
      @(posedge clk);
      #1;
    end
    check_output("break_busy_high", {31'd0, busy_o}, 32'd1);
    check_output("break_data_kept", {24'd0, data_o}, {24'd0, model_data});
    check_output("break_one_err", err_count - errs0, 1);
    wait_idle(20);

    // Reset during bit 4 of an aborted frame
    pulses0 = pulse_count;
    partial = 8'h96;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i], 1'b0);
    rx_i = partial[4];
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    rx_i       = 1'b1;
    model_data = 8'h00;
    check_output("midreset_data_o", {24'd0, data_o}, 32'd0);
    check_output("midreset_valid_o", {31'd0, valid_o}, 32'd0);
    check_output("midreset_frame_err_o", {31'd0, frame_err_o}, 32'd0);
    check_output("midreset_busy_o", {31'd0, busy_o}, 32'd0);
    idle(20);
    check_output("midreset_no_pulse", pulse_count - pulses0, 0);
    send_frame(8'h69, 1'b1, 1'b0, t0);
    wait_idle(200);

    // One-cycle inverted glitch at every data bit sample point
    send_frame(8'hC3, 1'b1, 1'b1, t0);
    wait_idle(200);
    idle(3);

    // Randomized frames, gaps and stop-bit errors
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, ~bad, 1'b0, t0);
      if (bad) idle($urandom_range(3, 20));
      else     idle($urandom_range(0, 20));
    end
    wait_idle(400);
    check_output("queue_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
